// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one valid/ready memory port between an instruction
//               fetch requester (port 0) and a data requester (port 1).
//               The grant is held until the memory accepts the request. An
//               in-order tag FIFO records the owner of every accepted request
//               so that each response can be routed back to that owner.
//               Optional macro ARB_P1_PRIORITY_EN: when it is defined, port 1
//               wins every tie in ARB. When it is undefined, ties are
//               resolved round-robin.
// Revision    : 1.0 - initial release
// ============================================================================

package mem_port_arbiter_pkg;
    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_pkt_t;
endpackage

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               p0_req_vld,
    output logic                               p0_req_rdy,
    input  mem_pkt_t                           p0_req,
    output logic                               p0_rsp_vld,
    input  logic                               p0_rsp_rdy,
    output mem_pkt_t                           p0_rsp,
    input  logic                               p1_req_vld,
    output logic                               p1_req_rdy,
    input  mem_pkt_t                           p1_req,
    output logic                               p1_rsp_vld,
    input  logic                               p1_rsp_rdy,
    output mem_pkt_t                           p1_rsp,
    output logic                               mem_req_vld,
    input  logic                               mem_req_rdy,
    output mem_pkt_t                           mem_req,
    input  logic                               mem_rsp_vld,
    output logic                               mem_rsp_rdy,
    input  mem_pkt_t                           mem_rsp,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               orphan_rsp
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            g_q, g_d;
    logic            tags_q [MAX_OUTSTANDING];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            orphan_q;

    logic            w_full, w_empty;
    logic            w_grant, w_req_vld, w_sel_active;
    logic            w_push, w_pop, w_head, w_rsp_rdy;
    logic            w_tie_pick;

    assign w_full  = (count_q == CW'(MAX_OUTSTANDING));
    assign w_empty = (count_q == '0);

`ifdef ARB_P1_PRIORITY_EN
    // On a tie the data port always wins, so no fairness history is kept.
    assign w_tie_pick = 1'b1;
`else
    logic rr_q;
    // rr holds the last granted port. On a tie the other port is granted.
    assign w_tie_pick = ~rr_q;

    // Round-robin history is updated on every accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rr_q <= 1'b0;
        else if (w_push) rr_q <= w_grant;
    end
`endif

    // Grant selection and next-state logic for the ARB/HOLD FSM.
    always_comb begin
        w_grant      = 1'b0;
        w_req_vld    = 1'b0;
        w_sel_active = 1'b0;
        state_d      = state_q;
        g_d          = g_q;
        case (state_q)
            ARB: begin
                if (!w_full && (p0_req_vld || p1_req_vld)) begin
                    w_req_vld    = 1'b1;
                    w_sel_active = 1'b1;
                    w_grant      = (p0_req_vld && p1_req_vld) ? w_tie_pick : p1_req_vld;
                    if (!mem_req_rdy) begin
                        state_d = HOLD;
                        g_d     = w_grant;
                    end
                end
            end
            HOLD: begin
                // The grant stays locked until the memory accepts the request.
                w_sel_active = 1'b1;
                w_grant      = g_q;
                w_req_vld    = g_q ? p1_req_vld : p0_req_vld;
                if (w_req_vld && mem_req_rdy) state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    assign w_push      = w_req_vld & mem_req_rdy;
    assign mem_req     = w_grant ? p1_req : p0_req;
    assign mem_req_vld = rst_n & w_req_vld;
    assign p0_req_rdy  = rst_n & w_sel_active & ~w_grant & mem_req_rdy;
    assign p1_req_rdy  = rst_n & w_sel_active &  w_grant & mem_req_rdy;

    // Route each response to the owner at the FIFO head. With no owner, the response is dropped.
    always_comb begin
        w_head     = tags_q[rd_ptr_q];
        w_rsp_rdy  = 1'b1;
        p0_rsp_vld = 1'b0;
        p1_rsp_vld = 1'b0;
        if (!w_empty) begin
            w_rsp_rdy  = w_head ? p1_rsp_rdy : p0_rsp_rdy;
            p0_rsp_vld = rst_n & mem_rsp_vld & ~w_head;
            p1_rsp_vld = rst_n & mem_rsp_vld &  w_head;
        end
    end

    assign mem_rsp_rdy = rst_n & w_rsp_rdy;
    assign w_pop       = ~w_empty & mem_rsp_vld & w_rsp_rdy;
    assign p0_rsp      = mem_rsp;
    assign p1_rsp      = mem_rsp;

    assign count_d     = count_q + CW'(w_push) - CW'(w_pop);
    assign outstanding = count_q;
    assign orphan_rsp  = orphan_q;

    // FSM state and latched grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            g_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
        end
    end

    // Tag FIFO storage, pointers and occupancy. The pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) tags_q[i] <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                tags_q[wr_ptr_q] <= w_grant;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (w_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Sticky flag for a response that arrives with no outstanding owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      orphan_q <= 1'b0;
        else if (w_empty && mem_rsp_vld) orphan_q <= 1'b1;
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n;
    logic     p0_req_vld, p0_req_rdy, p0_rsp_vld, p0_rsp_rdy;
    logic     p1_req_vld, p1_req_rdy, p1_rsp_vld, p1_rsp_rdy;
    mem_pkt_t p0_req, p0_rsp, p1_req, p1_rsp;
    logic     mem_req_vld, mem_req_rdy, mem_rsp_vld, mem_rsp_rdy;
    mem_pkt_t mem_req, mem_rsp;
    logic [2:0] outstanding;
    logic     orphan_rsp;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_vld(p0_req_vld), .p0_req_rdy(p0_req_rdy), .p0_req(p0_req),
        .p0_rsp_vld(p0_rsp_vld), .p0_rsp_rdy(p0_rsp_rdy), .p0_rsp(p0_rsp),
        .p1_req_vld(p1_req_vld), .p1_req_rdy(p1_req_rdy), .p1_req(p1_req),
        .p1_rsp_vld(p1_rsp_vld), .p1_rsp_rdy(p1_rsp_rdy), .p1_rsp(p1_rsp),
        .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req(mem_req),
        .mem_rsp_vld(mem_rsp_vld), .mem_rsp_rdy(mem_rsp_rdy), .mem_rsp(mem_rsp),
        .outstanding(outstanding), .orphan_rsp(orphan_rsp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic mem_pkt_t pkt(input logic [31:0] addr, input logic [31:0] data);
        mem_pkt_t p;
        p.we = 1'b0; p.be = 4'hF; p.addr = addr; p.data = data;
        return p;
    endfunction

    initial begin
        rst_n = 1'b0;
        p0_req_vld = 0; p1_req_vld = 0; p0_rsp_rdy = 0; p1_rsp_rdy = 0;
        mem_req_rdy = 0; mem_rsp_vld = 0;
        p0_req = pkt(32'h0, 32'h0); p1_req = pkt(32'h0, 32'h0); mem_rsp = pkt(32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_orphan", 64'(orphan_rsp), 64'd0);
        check("rst_mem_req_vld", 64'(mem_req_vld), 64'd0);
        check("rst_mem_rsp_rdy", 64'(mem_rsp_rdy), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single fetch
        p0_req = pkt(32'h100, 32'h0); p0_req_vld = 1; mem_req_rdy = 1;
        #1;
        check("fetch_mem_vld", 64'(mem_req_vld), 64'd1);
        check("fetch_mem_addr", 64'(mem_req.addr), 64'h100);
        check("fetch_p0_rdy", 64'(p0_req_rdy), 64'd1);
        check("fetch_p1_rdy", 64'(p1_req_rdy), 64'd0);
        tick();
        p0_req_vld = 0;
        check("fetch_outstanding1", 64'(outstanding), 64'd1);
        mem_rsp = pkt(32'h100, 32'hDEADBEEF); mem_rsp_vld = 1; p0_rsp_rdy = 1; p1_rsp_rdy = 1;
        #1;
        check("fetch_p0_rsp_vld", 64'(p0_rsp_vld), 64'd1);
        check("fetch_p1_rsp_vld", 64'(p1_rsp_vld), 64'd0);
        check("fetch_p0_rsp_data", 64'(p0_rsp.data), 64'hDEADBEEF);
        check("fetch_mem_rsp_rdy", 64'(mem_rsp_rdy), 64'd1);
        tick();
        mem_rsp_vld = 0;
        check("fetch_outstanding0", 64'(outstanding), 64'd0);

        // Contention: both valid for 4 cycles
        p0_req = pkt(32'h200, 32'h0); p1_req = pkt(32'h300, 32'h0);
        p0_req_vld = 1; p1_req_vld = 1; mem_req_rdy = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
`ifdef ARB_P1_PRIORITY_EN
            check("cont_addr", 64'(mem_req.addr), 64'h300);
            check("cont_p1_rdy", 64'(p1_req_rdy), 64'd1);
`else
            check("cont_addr", 64'(mem_req.addr), (i % 2 == 0) ? 64'h300 : 64'h200);
            check("cont_p1_rdy", 64'(p1_req_rdy), (i % 2 == 0) ? 64'd1 : 64'd0);
`endif
            tick();
        end
        p0_req_vld = 0; p1_req_vld = 0;
        check("cont_outstanding", 64'(outstanding), 64'd4);
        mem_rsp_vld = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
`ifdef ARB_P1_PRIORITY_EN
            check("cont_rsp_p1", 64'(p1_rsp_vld), 64'd1);
`else
            check("cont_rsp_p1", 64'(p1_rsp_vld), (i % 2 == 0) ? 64'd1 : 64'd0);
`endif
            tick();
        end
        mem_rsp_vld = 0;
        check("cont_drained", 64'(outstanding), 64'd0);

        // Backpressure hold
        p0_req = pkt(32'h400, 32'h0); p1_req = pkt(32'h500, 32'h0);
        p0_req_vld = 1; mem_req_rdy = 0;
        #1;
        check("hold_c1_addr", 64'(mem_req.addr), 64'h400);
        check("hold_c1_p0_rdy", 64'(p0_req_rdy), 64'd0);
        tick();
        p1_req_vld = 1;
        #1;
        check("hold_c2_addr", 64'(mem_req.addr), 64'h400);
        check("hold_c2_p1_rdy", 64'(p1_req_rdy), 64'd0);
        tick();
        #1;
        check("hold_c3_addr", 64'(mem_req.addr), 64'h400);
        check("hold_c3_vld", 64'(mem_req_vld), 64'd1);
        tick();
        mem_req_rdy = 1;
        #1;
        check("hold_c4_addr", 64'(mem_req.addr), 64'h400);
        check("hold_c4_p0_rdy", 64'(p0_req_rdy), 64'd1);
        check("hold_c4_p1_rdy", 64'(p1_req_rdy), 64'd0);
        tick();
        p0_req_vld = 0;
        #1;
        check("hold_p1_next", 64'(p1_req_rdy), 64'd1);
        tick();
        p1_req_vld = 0;
        mem_rsp_vld = 1;
        #1;
        check("hold_rsp0_p0", 64'(p0_rsp_vld), 64'd1);
        tick();
        #1;
        check("hold_rsp1_p1", 64'(p1_rsp_vld), 64'd1);
        tick();
        mem_rsp_vld = 0;
        check("hold_drained", 64'(outstanding), 64'd0);

        // FIFO full (pointers also wrap here)
        p0_req = pkt(32'h600, 32'h0); p0_req_vld = 1;
        repeat (4) tick();
        check("full_outstanding", 64'(outstanding), 64'd4);
        p1_req_vld = 1;
        #1;
        check("full_mem_vld", 64'(mem_req_vld), 64'd0);
        check("full_p0_rdy", 64'(p0_req_rdy), 64'd0);
        check("full_p1_rdy", 64'(p1_req_rdy), 64'd0);
        p1_req_vld = 0;
        mem_rsp_vld = 1;
        #1;
        check("full_pop_p0_rdy", 64'(p0_req_rdy), 64'd0);
        check("full_pop_rsp", 64'(p0_rsp_vld), 64'd1);
        tick();
        mem_rsp_vld = 0;
        #1;
        check("full_after_pop", 64'(outstanding), 64'd3);
        check("full_fifth_rdy", 64'(p0_req_rdy), 64'd1);
        tick();
        p0_req_vld = 0;
        check("full_again", 64'(outstanding), 64'd4);
        mem_rsp_vld = 1;
        repeat (4) tick();
        mem_rsp_vld = 0;
        check("full_drained", 64'(outstanding), 64'd0);

        // Ordered routing with response stall
        p1_req_vld = 1; tick(); p1_req_vld = 0;
        p0_req_vld = 1; tick(); p0_req_vld = 0;
        p1_req_vld = 1; tick(); p1_req_vld = 0;
        check("ord_outstanding", 64'(outstanding), 64'd3);
        mem_rsp_vld = 1; p1_rsp_rdy = 0; p0_rsp_rdy = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("ord_stall_vld", 64'(p1_rsp_vld), 64'd1);
            check("ord_stall_rdy", 64'(mem_rsp_rdy), 64'd0);
            tick();
        end
        p1_rsp_rdy = 1;
        #1;
        check("ord_r0_p1", 64'(p1_rsp_vld), 64'd1);
        check("ord_r0_rdy", 64'(mem_rsp_rdy), 64'd1);
        tick();
        check("ord_r1_p0", 64'(p0_rsp_vld), 64'd1);
        check("ord_r1_not_p1", 64'(p1_rsp_vld), 64'd0);
        tick();
        check("ord_r2_p1", 64'(p1_rsp_vld), 64'd1);
        tick();
        mem_rsp_vld = 0;
        check("ord_drained", 64'(outstanding), 64'd0);

        // Orphan response
        mem_rsp_vld = 1;
        #1;
        check("orph_rdy", 64'(mem_rsp_rdy), 64'd1);
        check("orph_p0_vld", 64'(p0_rsp_vld), 64'd0);
        check("orph_p1_vld", 64'(p1_rsp_vld), 64'd0);
        tick();
        mem_rsp_vld = 0;
        check("orph_set", 64'(orphan_rsp), 64'd1);
        tick();
        check("orph_sticky", 64'(orphan_rsp), 64'd1);

        // Reset in the middle of a held request with one outstanding
        p1_req_vld = 1; tick(); p1_req_vld = 0;
        p0_req_vld = 1; mem_req_rdy = 0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_orphan", 64'(orphan_rsp), 64'd0);
        check("arst_outstanding", 64'(outstanding), 64'd0);
        check("arst_mem_vld", 64'(mem_req_vld), 64'd0);
        check("arst_p0_rdy", 64'(p0_req_rdy), 64'd0);
        p0_req_vld = 0;
        tick();
        rst_n = 1'b1;
        mem_rsp_vld = 1;
        #1;
        check("arst_post_orphan_vld", 64'(p1_rsp_vld), 64'd0);
        tick();
        mem_rsp_vld = 0;
        check("arst_post_orphan", 64'(orphan_rsp), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one mem_pkt_t valid/ready memory port between the core's instruction-fetch requester (port 0) and data requester (port 1).
- Arbitrates requests and holds the grant stable until the memory accepts the request.
- Records the owner of each accepted request in an in-order tag FIFO, then routes each response back to its owner.
- Sits between the core's imem/dmem ports and a single-ported memory or bus bridge.

Parameters:
- MAX_OUTSTANDING, 4: depth of the tag FIFO; maximum accepted requests that have no response yet. Power of two, ≥2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- p0_req_vld  in  1  fetch request valid
- p0_req_rdy  out  1  fetch request accepted this cycle when high with vld
- p0_req  in  mem_pkt_t  fetch request packet
- p0_rsp_vld  out  1  fetch response valid
- p0_rsp_rdy  in  1  fetch side can take response
- p0_rsp  out  mem_pkt_t  fetch response packet
- p1_req_vld / p1_req_rdy / p1_req / p1_rsp_vld / p1_rsp_rdy / p1_rsp  same as p0, data requester
- mem_req_vld  out  1  request to memory valid
- mem_req_rdy  in  1  memory accepts request
- mem_req  out  mem_pkt_t  muxed request packet
- mem_rsp_vld  in  1  memory response valid
- mem_rsp_rdy  out  1  arbiter can take response
- mem_rsp  in  mem_pkt_t  memory response packet
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  current tag FIFO occupancy
- orphan_rsp  out  1  sticky: a response arrived with the tag FIFO empty

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty, outstanding=0, orphan_rsp=0.
  - Round-robin pointer rr=0, meaning port 1 has priority next.
  - State=ARB.
  - All vld/rdy outputs 0.
- Grant FSM, state ARB:
  - If the FIFO is not full and any pX_req_vld, choose grant g.
  - One requester valid: that requester.
  - Both valid: the port not granted last, per rr.
  - Drive mem_req=pg_req and mem_req_vld=1, combinationally in the same cycle.
  - pg_req_rdy=mem_req_rdy; the other port's rdy=0.
  - Handshake (mem_req_vld & mem_req_rdy): push g into FIFO, rr<=g, stay in ARB.
  - No handshake: latch g and go to HOLD.
- Grant FSM, state HOLD:
  - Grant is fixed to the latched g regardless of the other port.
  - mem_req_vld=pg_req_vld, so the requester must not drop vld.
  - On handshake: push, rr<=g, go to ARB.
- FIFO full in ARB: mem_req_vld=0 and both req_rdy=0. Push and pop in the same cycle while full is not used to accept; the request waits one cycle.
- Response path:
  - head = FIFO head tag.
  - p[head]_rsp_vld=mem_rsp_vld; the other rsp_vld=0.
  - mem_rsp_rdy=p[head]_rsp_rdy.
  - Both rsp ports carry mem_rsp unchanged.
  - Pop when mem_rsp_vld & mem_rsp_rdy.
- Zero-latency memory: a response in the same cycle as its request is not supported. A response must come at least 1 cycle after its request handshake.
- Simultaneous push and pop when not full: occupancy unchanged, pointers both advance, wrap modulo MAX_OUTSTANDING.
- FIFO empty and mem_rsp_vld:
  - mem_rsp_rdy=1 and the response is dropped.
  - Both rsp_vld=0.
  - orphan_rsp<=1, cleared only by reset.
- outstanding = push count − pop count, range 0..MAX_OUTSTANDING.
- Reset mid-transaction: all state cleared immediately. In-flight responses after reset are treated as orphans.

Optional Feature:
- Macro ARB_P1_PRIORITY_EN.
  - Defined: ARB uses fixed priority, port 1 (data) wins every tie and rr is unused. HOLD behaviour is unchanged.
  - Undefined: round-robin as above.

Test Plan:
- Single fetch: p0 vld, addr 0x100, mem_req_rdy=1. Expect mem_req.addr=0x100 in the same cycle and outstanding=1. A response with data 0xDEADBEEF one cycle later appears only on p0_rsp; outstanding=0.
- Contention: p0 and p1 held valid every cycle, mem_req_rdy=1. Expect grants in order p1,p0,p1,p0 (without macro). With ARB_P1_PRIORITY_EN, expect p1 every cycle.
- Backpressure hold: p0 valid while mem_req_rdy=0 for 3 cycles, p1 raised in cycle 2. Expect mem_req to stay p0's packet for all 3 cycles and p1_req_rdy=0. p0 is accepted in cycle 4.
- FIFO full: 4 requests accepted with no responses. Expect outstanding=4 and both req_rdy=0 on a 5th request. After one response pops, the 5th is accepted the following cycle.
- Ordered routing: accept p1, p0, p1, then return 3 responses with p1_rsp_rdy=0 for 2 cycles. Expect mem_rsp_rdy=0 while stalled, then delivery to p1, p0, p1 in that order.
- Orphan and reset: mem_rsp_vld with the FIFO empty. Expect orphan_rsp=1 that stays high. Assert rst_n=0 mid-stream: expect every output at its reset value asynchronously.
